mem_block_responder: RTL and testbench
======================================

# mem_block_responder

Memory-side responder for the data cache's block-fill and write-through interface. It accepts a single-word write (`memwrite`) or a block-fill read (`memread`) from the cache, waits a programmable latency, then commits the write or returns a whole `blocksize`-word block on `memdata` with a one-cycle `ready` strobe. It sits behind the data cache as the main-memory model used in simulation and FPGA builds, and replaces direct instantiation of a flat `dmem`.

## Interface
- `blocksize`, 4: words per cache block. Must be a power of two and at least 2.
- `depth`, 16384: number of 32-bit words of storage. Must be a power of two.
- `latency`, 4: number of BUSY cycles per access. Must be at least 1.
- `clk`, input, 1: sole clock, rising-edge.
- `reset`, input, 1: asynchronous, active-low (0 = reset).
- `memread`, input, 1: block-fill request. Held by the cache while it is stalled.
- `memwrite`, input, 1: single-word write request. Held by the cache while it is stalled.
- `a`, input, 32: byte address. `a[1:0]` is ignored.
- `wd`, input, 32: write data for `memwrite`.
- `memdata`, output, `blocksize*32`: returned block.
- `ready`, output, 1: one-cycle completion strobe for both reads and writes.
- `err`, output, 1: address out of range. Present only with the macro; tied to 0 otherwise.

## Operation
- The state machine has three states: IDLE, BUSY and DONE.
- **IDLE.** Requests are sampled only in IDLE.
  - At a rising edge with `memwrite|memread`: capture `a` and `wd`, latch the op (write has priority when both are high), load `cnt = latency-1`, go to BUSY.
- **BUSY.**
  - When `cnt != 0`: decrement `cnt`.
  - When `cnt == 0`: perform the access and go to DONE.
- **DONE.** `ready` = 1. On the next edge, go to IDLE unconditionally. Requests are not sampled in DONE, so the cache has one cycle to drop `memread`/`memwrite`.
- **Block base.** Word index = `a[31:2]` modulo `depth`. Block base = word index with its low log2(blocksize) bits cleared.
- **Read.** `memdata` is loaded with words base..base+blocksize-1. Word base+0 goes in the most significant slice `memdata[blocksize*32-1 -: 32]` and word base+blocksize-1 in `memdata[31:0]`. This matches the cache's `a[3:2]` select (00 → top slice).
- **Write.** Only the addressed word is updated. `memdata` is unchanged by writes.
- **Hold.** `memdata` holds its value until the next read completes.
- **Reset.** `ready` = 0, `memdata` = 0, `err` = 0, `cnt` = 0, state = IDLE.
  - Storage is not cleared.
  - Reset asserted mid-access aborts the access: a pending write is not committed and `memdata` is zeroed.
- **Counter width.** `cnt` is $clog2(latency+1) bits. It never wraps because it is loaded only in IDLE.

## Timing
- Request sampled at edge E0. The state is BUSY during cycles E0..E0+latency.
- The access is performed and `memdata` is registered at edge E0+latency. `ready` is high for exactly the following cycle.
- Total latency from request to `ready` is latency+1 cycles. The minimum request-to-request spacing is latency+2 edges.
- `memdata` is valid in the same cycle `ready` is high, and later.
- A request that is still high when the state returns to IDLE is treated as a new request.
- Changes to `a` or `wd` during BUSY/DONE are ignored because the values are captured at E0.
- `memread` and `memwrite` both high at E0: only the write is performed. The read must be re-requested.

## Configuration
- `MEMRESP_RANGE_CHECK_EN` defined:
  - A request with `a[31:2] >= depth` is not wrapped. The read returns all zeros, or the write is dropped.
  - `err` is high in DONE together with `ready`, and is 0 otherwise.
- `MEMRESP_RANGE_CHECK_EN` undefined:
  - The address wraps modulo `depth`.
  - `err` is constant 0.
  - No comparator logic is built.

## Test plan
- **Reset.** Reset low, then release → `ready`=0, `memdata`=0 and state IDLE, with no `ready` pulse for 10 cycles when there are no requests.
- **Write then fill.** Write `wd`=0xDEADBEEF to `a`=0x104, then read `a`=0x10C.
  - `ready` comes latency+1 cycles after each request.
  - Expected `memdata` = {mem[0x40], 0xDEADBEEF, mem[0x42], mem[0x43]}, with word 0x41 in bits [95:64].
- **Simultaneous request.** `memread`=`memwrite`=1 with `a`=0x20, `wd`=0x5 → one `ready`, mem[8]=5, `memdata` unchanged. A following read of 0x20 returns 5 in the top slice.
- **Held request.** Hold `memread` high for 2*(latency+2) cycles → exactly two `ready` pulses, spaced latency+2 cycles apart.
- **Reset mid-write.** Write 0x1234 to 0x0 and assert `reset` in BUSY → no `ready`, `memdata`=0, and a following read of 0x0 returns the old value.
- **Out of range.** With `depth`=1024 and `a`=0x1004 (word 1025):
  - With `MEMRESP_RANGE_CHECK_EN`: `err`=1 with `ready` and `memdata`=0.
  - Without it: the access aliases to word 1.

Source files
------------

// File: rtl/mem_block_responder.sv
// Memory-side responder: single-word write-through and block-fill read after a fixed latency.
// Optional macro MEMRESP_RANGE_CHECK_EN: out-of-range addresses raise err instead of wrapping.
module mem_block_responder #(
  parameter int blocksize = 4,
  parameter int depth     = 16384,
  parameter int latency   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    memread,
  input  logic                    memwrite,
  input  logic [31:0]             a,
  input  logic [31:0]             wd,
  output logic [blocksize*32-1:0] memdata,
  output logic                    ready,
  output logic                    err
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(latency + 1);
  localparam int DW = blocksize * 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_wr_q, op_wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wd_q, wd_d;
  logic [DW-1:0]   memdata_q, memdata_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [depth];
  logic [AW-1:0]   base_s;
  logic [DW-1:0]   rd_block_s;
  logic            access_s;
  logic            wr_en_s;
  logic            oor_s;
  logic            unused_a_s;

  assign unused_a_s = ^{a[1:0], a[31:AW+2]};

`ifdef MEMRESP_RANGE_CHECK_EN
  logic oor_q, oor_d;

  // Out-of-range flag is captured with the address so later changes to a are ignored
  always_comb begin
    oor_d = oor_q;
    if ((state_q == IDLE) && (memwrite || memread)) begin
      oor_d = ({2'b00, a[31:2]} >= 32'(depth));
    end else begin
      oor_d = oor_q;
    end
  end

  // Out-of-range flag register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oor_q <= 1'b0;
    end else begin
      oor_q <= oor_d;
    end
  end

  assign oor_s = oor_q;
`else
  assign oor_s = 1'b0;
`endif

  assign base_s   = addr_q & ~AW'(blocksize - 1);
  assign access_s = (state_q == BUSY) && (cnt_q == {CW{1'b0}});
  assign wr_en_s  = access_s && op_wr_q && !oor_s;

  // Block gather: word base+0 lands in the most significant slice
  always_comb begin
    rd_block_s = {DW{1'b0}};
    for (int i = 0; i < blocksize; i++) begin
      rd_block_s[DW-32-32*i +: 32] = oor_s ? 32'h0000_0000 : mem_q[base_s | AW'(i)];
    end
  end

  // Next-state and next-output computation for the IDLE/BUSY/DONE sequence
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    memdata_d = memdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (memwrite || memread) begin
          op_wr_d = memwrite;
          addr_d  = a[AW+1:2];
          wd_d    = wd;
          cnt_d   = CW'(latency - 1);
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != {CW{1'b0}}) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = DONE;
          ready_d = 1'b1;
          err_d   = oor_s;
          if (op_wr_q) begin
            memdata_d = memdata_q;
          end else begin
            memdata_d = rd_block_s;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any in-flight access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      op_wr_q   <= 1'b0;
      addr_q    <= {AW{1'b0}};
      wd_q      <= 32'h0000_0000;
      memdata_q <= {DW{1'b0}};
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
      memdata_q <= memdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  // Storage array: deliberately not reset so contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[addr_q] <= wd_q;
    end
  end

  assign memdata = memdata_q;
  assign ready   = ready_q;
`ifdef MEMRESP_RANGE_CHECK_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_block_responder.sv
// Scoreboard bench for mem_block_responder: driver predicts responses from a word-array model,
// a negedge monitor pops and compares whenever ready is seen.
module tb_mem_block_responder;

  localparam int BS    = 4;
  localparam int DEPTH = 1024;
  localparam int LAT   = 4;
  localparam int DW    = BS * 32;
  localparam int NINIT = 72;

  logic          clk = 1'b0;
  logic          reset;
  logic          memread;
  logic          memwrite;
  logic [31:0]   a;
  logic [31:0]   wd;
  logic [DW-1:0] memdata;
  logic          ready;
  logic          err;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [31:0]   model [DEPTH];
  logic [DW-1:0] last_rd;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            pulse_cnt = 0;
  exp_t          mon_e;

  mem_block_responder #(
    .blocksize(BS),
    .depth    (DEPTH),
    .latency  (LAT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .memread (memread),
    .memwrite(memwrite),
    .a       (a),
    .wd      (wd),
    .memdata (memdata),
    .ready   (ready),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference behaviour: word-addressed array, top slice holds the block's first word
  task automatic predict(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, output exp_t e);
    int  idx;
    int  base;
    logic oor;
    idx  = int'(addr[31:2] % DEPTH);
    oor  = 1'b0;
`ifdef MEMRESP_RANGE_CHECK_EN
    oor  = (addr[31:2] >= DEPTH);
`endif
    e.err = oor;
    if (oor) begin
      if (!wr) last_rd = '0;
    end else if (wr) begin
      model[idx] = data;
    end else begin
      base = idx - (idx % BS);
      for (int i = 0; i < BS; i++) last_rd[DW-32-32*i +: 32] = model[base + i];
    end
    if (!rd && !wr) $display("note: empty request");
    e.data = last_rd;
  endtask

  // One request, released only once ready is seen; inputs scrambled after capture
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   t;
    @(negedge clk);
    memread = rd; memwrite = wr; a = addr; wd = data;
    @(posedge clk); #1;
    predict(rd, wr, addr, data, e);
    e.due = cyc + LAT;
    sb.push_back(e);
    a  = $urandom;
    wd = $urandom;
    t  = 0;
    do begin
      @(negedge clk);
      t++;
    end while (ready !== 1'b1 && t < 20);
    if (ready !== 1'b1) begin
      chk("ready_timeout", {{(DW-1){1'b0}}, ready}, {{(DW-1){1'b0}}, 1'b1});
      if (sb.size() != 0) void'(sb.pop_front());
    end
    memread = 1'b0; memwrite = 1'b0;
  endtask

  // Monitor: every ready pulse must match the oldest outstanding prediction
  always @(negedge clk) begin
    if (reset === 1'b1 && ready === 1'b1) begin
      pulse_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_ready", {{(DW-1){1'b0}}, ready}, {DW{1'b0}});
      end else begin
        mon_e = sb.pop_front();
        chk("memdata", memdata, mon_e.data);
        chk("err", {{(DW-1){1'b0}}, err}, {{(DW-1){1'b0}}, mon_e.err});
        chk("ready_cycle", DW'(cyc), DW'(mon_e.due));
      end
    end
  end

  initial begin
    exp_t e;
    int   t0;
    int   p0;
    logic [31:0] addr;
    reset = 1'b0; memread = 1'b0; memwrite = 1'b0; a = '0; wd = '0;
    last_rd = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Reset behaviour
    repeat (3) @(negedge clk);
    chk("rst_ready", {{(DW-1){1'b0}}, ready}, {DW{1'b0}});
    chk("rst_memdata", memdata, {DW{1'b0}});
    chk("rst_err", {{(DW-1){1'b0}}, err}, {DW{1'b0}});
    reset = 1'b1;
    p0 = pulse_cnt;
    repeat (10) @(negedge clk);
    chk("idle_no_ready", DW'(pulse_cnt - p0), {DW{1'b0}});
    chk("idle_memdata", memdata, {DW{1'b0}});

    // Fill the region the later reads touch
    for (int i = 0; i < NINIT; i++) issue(1'b0, 1'b1, 32'(i * 4), $urandom);

    // Write then block fill
    issue(1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 32'h0000_010C, 32'h0);
    chk("fill_word41", DW'(memdata[95:64]), DW'(32'hDEAD_BEEF));

    // Simultaneous request: write wins, memdata untouched
    p0 = pulse_cnt;
    issue(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0005);
    chk("simul_one_ready", DW'(pulse_cnt - p0), DW'(1));
    issue(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    chk("simul_top_slice", DW'(memdata[DW-1 -: 32]), DW'(32'h5));

    // Held request: two completions, latency+2 apart
    @(negedge clk);
    memread = 1'b1; memwrite = 1'b0; a = 32'h0000_0040; wd = '0;
    @(posedge clk); #1;
    t0 = cyc;
    p0 = pulse_cnt;
    predict(1'b1, 1'b0, 32'h0000_0040, 32'h0, e);
    e.due = t0 + LAT;
    sb.push_back(e);
    e.due = t0 + 2 * LAT + 2;
    sb.push_back(e);
    repeat (2 * (LAT + 2)) @(negedge clk);
    memread = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_two_pulses", DW'(pulse_cnt - p0), DW'(2));

    // Reset during a write's BUSY phase aborts it
    @(negedge clk);
    memwrite = 1'b1; a = 32'h0; wd = 32'h0000_1234;
    @(posedge clk); #1;
    p0 = pulse_cnt;
    @(negedge clk);
    reset = 1'b0; memwrite = 1'b0;
    #1;
    chk("abort_memdata", memdata, {DW{1'b0}});
    chk("abort_ready", {{(DW-1){1'b0}}, ready}, {DW{1'b0}});
    last_rd = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_ready", DW'(pulse_cnt - p0), {DW{1'b0}});
    issue(1'b1, 1'b0, 32'h0000_0000, 32'h0);

    // Address beyond depth (aliases to word 1 unless range checking is built in)
    issue(1'b1, 1'b0, 32'h0000_1004, 32'h0);
    issue(1'b0, 1'b1, 32'h0000_1004, 32'hA5A5_0001);
    issue(1'b1, 1'b0, 32'h0000_0004, 32'h0);

    // Randomised mix of reads, writes and simultaneous requests
    for (int n = 0; n < 40; n++) begin
      int idx;
      int up;
      int kind;
      idx  = $urandom_range(0, NINIT - 1);
      up   = 0;
`ifndef MEMRESP_RANGE_CHECK_EN
      up   = $urandom_range(0, 3);
`endif
      addr = 32'(((up * DEPTH) + idx) * 4) | ($urandom & 32'h3);
      kind = $urandom_range(0, 4);
      issue(kind != 1, kind <= 1, addr, $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", DW'(sb.size()), {DW{1'b0}});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
